// File: rtl/powlib_busarb_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
// Holds the FSM state encoding and a constant clog2 used for counter/index widths.
package powlib_busarb_pkg;

    typedef enum logic {
        POWLIB_BUSARB_IDLE  = 1'b0,
        POWLIB_BUSARB_GRANT = 1'b1
    } arb_state_t;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/powlib_busarb_rr.sv
// Rotating-priority picker: first requester at or after ptr, wrapping modulo N.
// Purely combinational, zero latency; no backpressure involvement.
// Backpressure: none, the caller decides when the pick is registered.
module powlib_busarb_rr #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  reqs,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Offset k is tried before k+1; constant j keeps every select static.
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (!any && reqs[j] && (((int'(ptr) + k) % N) == j)) begin
                    any       = 1'b1;
                    onehot[j] = 1'b1;
                    idx       = IW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/powlib_busarb.sv
// Round-robin, burst-locked arbiter sharing one addr/data/vld/rdy port among B_REQS requesters.
// Latency: 1 IDLE cycle to arbitrate, then 1 cycle registered output per beat.
// Backpressure: outrdy low with a held beat drops all inrdys; optional stats via POWLIB_BUSARB_STATS_EN.
module powlib_busarb
    import powlib_busarb_pkg::*;
#(
    parameter int          EAR       = 0,
    parameter logic [63:0] ID        = "ARB",
    parameter int          EDBG      = 0,
    parameter int          B_REQS    = 3,
    parameter int          B_AW      = 32,
    parameter int          B_DW      = 40,
    parameter int          MAX_BURST = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [B_AW*B_REQS-1:0]   inaddrs,
    input  logic [B_DW*B_REQS-1:0]   indatas,
    input  logic [B_REQS-1:0]        invlds,
    output logic [B_REQS-1:0]        inrdys,
    output logic [B_AW-1:0]          outaddr,
    output logic [B_DW-1:0]          outdata,
    output logic                     outvld,
    input  logic                     outrdy,
    output logic [B_REQS-1:0]        gnt
`ifdef POWLIB_BUSARB_STATS_EN
    ,
    output logic [32*B_REQS-1:0]     beatcnts
`endif
);

    localparam int IW = (clog2(B_REQS) < 1) ? 1 : clog2(B_REQS);
    localparam int CW = (clog2(MAX_BURST + 1) < 1) ? 1 : clog2(MAX_BURST + 1);

    arb_state_t        state, state_nxt;
    logic [B_REQS-1:0] gnt_q;
    logic [IW-1:0]     gidx;
    logic [IW-1:0]     ptr;
    logic [CW-1:0]     beatcnt;

    logic [B_REQS-1:0] pick_oh;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;

    logic              can_load;
    logic              sel_vld;
    logic [B_AW-1:0]   sel_addr;
    logic [B_DW-1:0]   sel_data;
    logic              accept;
    logic              last_beat;
    logic              release_gnt;
    logic              dp_clr;
    logic              unused_cfg;

    assign unused_cfg = (EDBG != 0) ^ (|ID);

    powlib_busarb_rr #(
        .N  (B_REQS),
        .IW (IW)
    ) u_rr (
        .reqs   (invlds),
        .ptr    (ptr),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        sel_vld  = 1'b0;
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < B_REQS; i++) begin
            if (gnt_q[i]) begin
                sel_vld  = invlds[i];
                sel_addr = inaddrs[B_AW*i +: B_AW];
                sel_data = indatas[B_DW*i +: B_DW];
            end
        end
    end

    assign can_load  = ~outvld | outrdy;
    assign accept    = (state == POWLIB_BUSARB_GRANT) & sel_vld & can_load;
    assign last_beat = (beatcnt == CW'(MAX_BURST - 1));
    assign inrdys    = ((state == POWLIB_BUSARB_GRANT) && can_load) ? gnt_q : '0;
    assign gnt       = gnt_q;

    // A granted requester dropping vld, even while stalled, gives up the port.
    always_comb begin
        state_nxt   = state;
        release_gnt = 1'b0;
        case (state)
            POWLIB_BUSARB_IDLE: begin
                if (pick_any) begin
                    state_nxt = POWLIB_BUSARB_GRANT;
                end
            end
            POWLIB_BUSARB_GRANT: begin
                if (!sel_vld || (accept && last_beat)) begin
                    release_gnt = 1'b1;
                    state_nxt   = POWLIB_BUSARB_IDLE;
                end
            end
            default: state_nxt = POWLIB_BUSARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= POWLIB_BUSARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt_q   <= '0;
            gidx    <= '0;
            ptr     <= '0;
            beatcnt <= '0;
        end else if ((state == POWLIB_BUSARB_IDLE) && pick_any) begin
            gnt_q   <= pick_oh;
            gidx    <= pick_idx;
            beatcnt <= '0;
        end else if (release_gnt) begin
            gnt_q   <= '0;
            ptr     <= (gidx == IW'(B_REQS - 1)) ? '0 : gidx + IW'(1);
            beatcnt <= '0;
        end else if (accept) begin
            beatcnt <= beatcnt + CW'(1);
        end
    end

    if (EAR != 0) begin : g_ear
        assign dp_clr = ~rst;
    end else begin : g_noear
        assign dp_clr = 1'b0;
    end

    // The held beat drains on outrdy regardless of grant state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outvld  <= 1'b0;
            outaddr <= '0;
            outdata <= '0;
        end else if (dp_clr) begin
            outvld  <= 1'b0;
            outaddr <= '0;
            outdata <= '0;
        end else if (accept) begin
            outvld  <= 1'b1;
            outaddr <= sel_addr;
            outdata <= sel_data;
        end else if (outrdy) begin
            outvld  <= 1'b0;
        end
    end

`ifdef POWLIB_BUSARB_STATS_EN
    logic [B_REQS-1:0][31:0] stat_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_q <= '0;
        end else begin
            for (int i = 0; i < B_REQS; i++) begin
                if (accept && gnt_q[i]) begin
                    stat_q[i] <= stat_q[i] + 32'd1;
                end
            end
        end
    end

    assign beatcnts = stat_q;
`endif

endmodule
